regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single write port of the 32x64 register file between N_REQ
//  write-back sources (ALU, load unit, multiplier). Each source gets a 1-entry
//  holding buffer behind a valid/ready handshake. A round-robin arbiter drains
//  the buffers into a registered write port. A pending-address mask feeds hazard/stall logic.
// PARAMETERS
//  N_REQ   3   number of write-back requesters (>=2)
//  DATA_W  64  write data width
//  ADDR_W  5   register address width (32 registers)
// PORTS
//  clk             in   1             clock, all state on posedge
//  rst             in   1             asynchronous, active-high reset
//  req_valid       in   N_REQ         per-requester write request
//  req_ready       out  N_REQ         per-requester buffer can accept
//  req_addr        in   N_REQ*ADDR_W  dest reg, requester i at [i*ADDR_W +: ADDR_W]
//  req_data        in   N_REQ*DATA_W  write data, requester i at [i*DATA_W +: DATA_W]
//  regWrite_en     out  1             to register file write enable
//  write_addr      out  ADDR_W        to register file write address
//  write_reg_data  out  DATA_W        to register file write data
//  pend_mask       out  32            bit r set = write to reg r not yet committed
//  idle            out  1             all buffers empty and regWrite_en low
// BEHAVIOUR
//  Reset (async, any time): buffers emptied, rr_ptr=0, regWrite_en=0,
//   write_addr=0, write_reg_data=0, pend_mask=0, idle=1; in-flight data dropped.
//  Buffer i: full bit + addr + data. Transfer on posedge when valid&ready.
//   req_ready[i] = !full[i] | grant[i] (same-cycle drain and refill allowed;
//   combinational from state only, never from req_valid).
//  Arbiter (combinational, per cycle): candidates = full buffers; grant the
//   first candidate at index rr_ptr, rr_ptr+1, ... mod N_REQ. One grant max.
//   On grant to i: rr_ptr <= (i+1) mod N_REQ; else rr_ptr holds.
//  Output stage (registered): next edge after grant, regWrite_en<=1 with
//   granted addr/data; no grant -> regWrite_en<=0, addr/data hold.
//  Reg 0: grant to addr 0 empties the buffer but regWrite_en<=0 (no write).
//  Latency: accept at edge E0 -> grant in cycle after E0 (if winner) ->
//   regWrite_en high after E1 -> register file captures at E2. Uncontended
//   throughput: one write per cycle per requester.
//  Ordering: writes from one requester commit in acceptance order. Same
//   address from different requesters commit in grant order; upstream owns
//   WAW ordering across requesters.
//  pend_mask = OR over full buffers of onehot(addr) | (regWrite_en ?
//   onehot(write_addr) : 0); bit 0 always 0. Combinational from state.
//  idle = no buffer full & !regWrite_en.
//  Starvation bound: a full buffer is granted within N_REQ cycles.
// TESTING
//  1 Reset: rst=1 mid-traffic -> immediately regWrite_en=0, req_ready=all 1,
//    pend_mask=0, idle=1; after release first grant goes to requester 0.
//  2 Single: req0 addr=5 data=0xDEAD_BEEF at E0 -> regWrite_en=1,
//    write_addr=5, data=0xDEADBEEF after E1; pend_mask[5]=1 from E0 to E2.
//  3 Contention: all 3 valid each cycle, addrs 1/2/3 -> grants 0,1,2,0,1,2;
//    each req_ready toggles once per 3 cycles, no data lost or duplicated.
//  4 Reg 0: req1 addr=0 data=0xFF -> buffer drains, regWrite_en stays 0,
//    pend_mask stays 0, req_ready[1] returns to 1.
//  5 Back-to-back: req2 streams addrs 7,8,9 with no competitors -> writes
//    7,8,9 on consecutive cycles, req_ready[2] held 1 throughout.
//  6 Async reset mid-grant: assert rst between edges with all buffers full ->
//    outputs clear before next edge; no write of buffered data after release.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the 32x64 register file: per-source 1-entry buffers,
// round-robin drain into a registered write port, plus a pending-write mask.
module regfile_wb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic                      regWrite_en,
  output logic [ADDR_W-1:0]         write_addr,
  output logic [DATA_W-1:0]         write_reg_data,
  output logic [31:0]               pend_mask,
  output logic                      idle
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  full_q, full_d;
  logic [ADDR_W-1:0] addr_q [N_REQ];
  logic [ADDR_W-1:0] addr_d [N_REQ];
  logic [DATA_W-1:0] data_q [N_REQ];
  logic [DATA_W-1:0] data_d [N_REQ];
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [N_REQ-1:0]  grant;
  logic              grant_any;
  logic [PTR_W-1:0]  grant_idx;
  logic [ADDR_W-1:0] grant_addr;
  logic              grant_writes;

  // Round-robin scan starting at rr_ptr; first full buffer wins.
  always_comb begin : p_arb
    int j;
    j         = 0;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!grant_any && full_q[j[PTR_W-1:0]]) begin
        grant_any             = 1'b1;
        grant_idx             = j[PTR_W-1:0];
        grant[j[PTR_W-1:0]]   = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_buf
      logic take;
      // Ready depends only on state, so a draining buffer can refill in the same cycle.
      assign req_ready[gi] = ~full_q[gi] | grant[gi];
      assign take          = req_valid[gi] & req_ready[gi];
      assign full_d[gi]    = take | (full_q[gi] & ~grant[gi]);
      assign addr_d[gi]    = take ? req_addr[gi*ADDR_W +: ADDR_W] : addr_q[gi];
      assign data_d[gi]    = take ? req_data[gi*DATA_W +: DATA_W] : data_q[gi];
    end
  endgenerate

  assign grant_addr   = addr_q[grant_idx];
  // Register 0 is hardwired: its grant just discards the entry.
  assign grant_writes = grant_any && (grant_addr != '0);

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      rr_ptr_d = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
    we_d    = grant_writes;
    waddr_d = grant_writes ? grant_addr : waddr_q;
    wdata_d = grant_writes ? data_q[grant_idx] : wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q   <= '0;
      rr_ptr_q <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      full_q   <= full_d;
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (full_q[i]) pend_mask = pend_mask | (32'(1) << addr_q[i]);
    end
    if (we_q) pend_mask = pend_mask | (32'(1) << waddr_q);
    pend_mask[0] = 1'b0;
  end

  assign regWrite_en    = we_q;
  assign write_addr     = waddr_q;
  assign write_reg_data = wdata_q;
  assign idle           = ~(|full_q) & ~we_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random
// traffic compared against a transaction-level reference model.
module tb_regfile_wb_arbiter;
  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [N*5-1:0]  req_addr = '0;
  logic [N*64-1:0] req_data = '0;
  logic          regWrite_en;
  logic [4:0]    write_addr;
  logic [63:0]   write_reg_data;
  logic [31:0]   pend_mask;
  logic          idle;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter #(.N_REQ(N), .DATA_W(64), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .regWrite_en(regWrite_en), .write_addr(write_addr),
    .write_reg_data(write_reg_data), .pend_mask(pend_mask), .idle(idle)
  );

  always #5 clk = ~clk;

  // Reference model: what each holding slot contains, whose turn it is,
  // and what the register file is being told to write this cycle.
  bit          m_full [N];
  logic [4:0]  m_addr [N];
  logic [63:0] m_data [N];
  int          m_turn;
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [63:0] m_wdata;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 0; m_addr[i] = '0; m_data[i] = '0;
    end
    m_turn = 0; m_we = 0; m_waddr = '0; m_wdata = '0;
  endfunction

  function automatic int model_winner();
    for (int k = 0; k < N; k++)
      if (m_full[(m_turn + k) % N]) return (m_turn + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int w;
    w = model_winner();
    for (int i = 0; i < N; i++) r[i] = !m_full[i] || (w == i);
    return r;
  endfunction

  function automatic logic [31:0] model_pend();
    logic [31:0] m;
    m = 0;
    for (int i = 0; i < N; i++) if (m_full[i] && m_addr[i] != 0) m[m_addr[i]] = 1'b1;
    if (m_we && m_waddr != 0) m[m_waddr] = 1'b1;
    return m;
  endfunction

  function automatic bit model_idle();
    bit any;
    any = 0;
    for (int i = 0; i < N; i++) any |= m_full[i];
    return !any && !m_we;
  endfunction

  task automatic set_req(input int i, input bit v, input logic [4:0] a, input logic [63:0] d);
    req_valid[i]        = v;
    req_addr[i*5 +: 5]   = a;
    req_data[i*64 +: 64] = d;
  endtask

  // Advance one clock: model consumes the current inputs, then DUT outputs settle.
  task automatic tick();
    int w;
    logic [N-1:0] rdy;
    w   = model_winner();
    rdy = model_ready();
    if (w >= 0) begin
      m_turn = (w + 1) % N;
      m_we   = (m_addr[w] != 0);
      if (m_we) begin m_waddr = m_addr[w]; m_wdata = m_data[w]; end
    end else begin
      m_we = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && rdy[i]) begin
        m_full[i] = 1; m_addr[i] = req_addr[i*5 +: 5]; m_data[i] = req_data[i*64 +: 64];
      end else if (w == i) begin
        m_full[i] = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (regWrite_en !== 1'b0) begin bad++; $display("FAIL rst0_we got=%b exp=0", regWrite_en); end
    total++; if (req_ready !== 3'b111) begin bad++; $display("FAIL rst0_ready got=%b exp=111", req_ready); end
    total++; if (pend_mask !== 32'h0 || idle !== 1'b1) begin bad++; $display("FAIL rst0_pend_idle got=%h/%b exp=0/1", pend_mask, idle); end
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1, 5'(10 + i), 64'(100 + i));
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    total++; if (regWrite_en !== 1'b0 || req_ready !== 3'b111) begin bad++; $display("FAIL rst_mid got we=%b rdy=%b exp 0/111", regWrite_en, req_ready); end
    total++; if (pend_mask !== 32'h0 || idle !== 1'b1) begin bad++; $display("FAIL rst_mid_pend got=%h/%b exp=0/1", pend_mask, idle); end
    model_reset();
    for (int i = 0; i < N; i++) set_req(i, 1, 5'(20 + i), 64'(200 + i));
    @(negedge clk); rst = 1'b0;
    tick(); req_valid = '0; tick();
    total++; if (regWrite_en !== 1'b1 || write_addr !== 5'd20 || write_reg_data !== 64'd200) begin
      bad++; $display("FAIL rst_first_grant got we=%b a=%0d d=%0d exp 1/20/200", regWrite_en, write_addr, write_reg_data); end
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 1, 5'd5, 64'hDEAD_BEEF);
    tick(); req_valid = '0;
    total++; if (pend_mask[5] !== 1'b1 || regWrite_en !== 1'b0) begin bad++; $display("FAIL single_e0 got pend5=%b we=%b exp 1/0", pend_mask[5], regWrite_en); end
    tick();
    total++; if (regWrite_en !== 1'b1 || write_addr !== 5'd5 || write_reg_data !== 64'hDEAD_BEEF) begin
      bad++; $display("FAIL single_e1 got we=%b a=%0d d=%h exp 1/5/deadbeef", regWrite_en, write_addr, write_reg_data); end
    total++; if (pend_mask !== 32'h20) begin bad++; $display("FAIL single_pend_e1 got=%h exp=20", pend_mask); end
    tick();
    total++; if (regWrite_en !== 1'b0 || pend_mask !== 32'h0 || idle !== 1'b1) begin
      bad++; $display("FAIL single_e2 got we=%b pend=%h idle=%b exp 0/0/1", regWrite_en, pend_mask, idle); end
  endtask

  task automatic test_contention();
    int writes[$];
    int accepted;
    int exp_seq[6] = '{1, 2, 3, 1, 2, 3};
    accepted = 0;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      for (int i = 0; i < N; i++) set_req(i, c < 10, 5'(1 + i), {32'(c), 32'(i)});
      total++; if (req_ready !== model_ready()) begin bad++; $display("FAIL cont_ready cyc=%0d got=%b exp=%b", c, req_ready, model_ready()); end
      for (int i = 0; i < N; i++) if (req_valid[i] && model_ready()[i]) accepted++;
      tick();
      total++; if (regWrite_en !== m_we || (m_we && (write_addr !== m_waddr || write_reg_data !== m_wdata))) begin
        bad++; $display("FAIL cont_write cyc=%0d got we=%b a=%0d d=%h exp %b/%0d/%h", c, regWrite_en, write_addr, write_reg_data, m_we, m_waddr, m_wdata); end
      if (regWrite_en) writes.push_back(int'(write_addr));
    end
    for (int k = 0; k < 6; k++) begin
      total++; if (k >= writes.size() || writes[k] !== exp_seq[k]) begin
        bad++; $display("FAIL cont_order idx=%0d got=%0d exp=%0d", k, (k < writes.size()) ? writes[k] : -1, exp_seq[k]); end
    end
    total++; if (writes.size() != accepted) begin bad++; $display("FAIL cont_count got=%0d exp=%0d", writes.size(), accepted); end
  endtask

  task automatic test_reg0();
    do_reset();
    set_req(1, 1, 5'd0, 64'hFF);
    tick(); req_valid = '0;
    total++; if (pend_mask !== 32'h0 || req_ready[1] !== 1'b1) begin bad++; $display("FAIL reg0_e0 got pend=%h rdy1=%b exp 0/1", pend_mask, req_ready[1]); end
    tick();
    total++; if (regWrite_en !== 1'b0 || idle !== 1'b1 || req_ready !== 3'b111 || pend_mask !== 32'h0) begin
      bad++; $display("FAIL reg0_e1 got we=%b idle=%b rdy=%b pend=%h exp 0/1/111/0", regWrite_en, idle, req_ready, pend_mask); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_req(2, 1, 5'(7 + k), 64'(70 + k));
      total++; if (req_ready[2] !== 1'b1) begin bad++; $display("FAIL b2b_ready k=%0d got=%b exp=1", k, req_ready[2]); end
      tick();
      if (k >= 1) begin
        total++; if (regWrite_en !== 1'b1 || write_addr !== 5'(6 + k)) begin bad++; $display("FAIL b2b_write k=%0d got we=%b a=%0d exp 1/%0d", k, regWrite_en, write_addr, 6 + k); end
      end
    end
    req_valid = '0;
    tick();
    total++; if (regWrite_en !== 1'b1 || write_addr !== 5'd9 || write_reg_data !== 64'd72) begin
      bad++; $display("FAIL b2b_last got we=%b a=%0d d=%0d exp 1/9/72", regWrite_en, write_addr, write_reg_data); end
    tick();
    total++; if (regWrite_en !== 1'b0 || idle !== 1'b1) begin bad++; $display("FAIL b2b_end got we=%b idle=%b exp 0/1", regWrite_en, idle); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1, 5'(13 + i), 64'(130 + i));
    tick(); req_valid = '0; tick();
    #2 rst = 1'b1;
    #1;
    total++; if (regWrite_en !== 1'b0 || pend_mask !== 32'h0 || idle !== 1'b1 || req_ready !== 3'b111) begin
      bad++; $display("FAIL arst_clear got we=%b pend=%h idle=%b rdy=%b exp 0/0/1/111", regWrite_en, pend_mask, idle, req_ready); end
    model_reset();
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++; if (regWrite_en !== 1'b0 || idle !== 1'b1) begin bad++; $display("FAIL arst_after cyc=%0d got we=%b idle=%b exp 0/1", c, regWrite_en, idle); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        set_req(i, ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 31)), {$urandom, $urandom});
      total++; if (req_ready !== model_ready() || pend_mask !== model_pend() || idle !== model_idle()) begin
        bad++; $display("FAIL rnd_state cyc=%0d got rdy=%b pend=%h idle=%b exp %b/%h/%b", c, req_ready, pend_mask, idle, model_ready(), model_pend(), model_idle()); end
      tick();
      total++; if (regWrite_en !== m_we || (m_we && (write_addr !== m_waddr || write_reg_data !== m_wdata))) begin
        bad++; $display("FAIL rnd_write cyc=%0d got we=%b a=%0d d=%h exp %b/%0d/%h", c, regWrite_en, write_addr, write_reg_data, m_we, m_waddr, m_wdata); end
    end
    req_valid = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_reg0();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
